// File: rtl/wb_regfile_if.sv
// Bus bundle between the ME->WB pipeline/ID stage and the writeback register file.
// wc_load/wc_load_val preset the commit counter so its wrap can be exercised.
interface wb_regfile_if;
  logic [31:0] ans_wb;
  logic [31:0] mo_wb;
  logic [4:0]  rw_wb;
  logic        wreg_wb;
  logic        rmem_wb;
  logic [4:0]  ra_id;
  logic [4:0]  rb_id;
  logic [31:0] qa_id;
  logic [31:0] qb_id;
  logic [31:0] wdata_wb;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] wcount;
  logic        wc_load;
  logic [31:0] wc_load_val;

  modport master (
    output ans_wb, mo_wb, rw_wb, wreg_wb, rmem_wb, ra_id, rb_id, dbg_addr,
           wc_load, wc_load_val,
    input  qa_id, qb_id, wdata_wb, dbg_data, wcount
  );

  modport slave (
    input  ans_wb, mo_wb, rw_wb, wreg_wb, rmem_wb, ra_id, rb_id, dbg_addr,
           wc_load, wc_load_val,
    output qa_id, qb_id, wdata_wb, dbg_data, wcount
  );
endinterface

// File: rtl/wb_regfile.sv
// 32x32 writeback register file with same-cycle write-to-read bypass,
// an unbypassed debug read port and a wrapping count of committed writes.
module wb_regfile (
  input  logic         clock,
  input  logic         reset,
  wb_regfile_if.slave  bus
);

  logic [31:0] regs_q [32];
  logic [31:0] wcount_q;
  logic [31:0] wcount_d;
  logic [31:0] wdata;
  logic        commit;

  assign wdata  = bus.rmem_wb ? bus.mo_wb : bus.ans_wb;
  assign commit = bus.wreg_wb && (bus.rw_wb != 5'd0);

  always_comb begin
    wcount_d = wcount_q;
    if (bus.wc_load)
      wcount_d = bus.wc_load_val;
    else if (commit)
      wcount_d = wcount_q + 32'd1;
  end

  // Entry 0 is never written; every read path masks address 0 anyway.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        regs_q[i] <= 32'd0;
      wcount_q <= 32'd0;
    end else begin
      if (commit)
        regs_q[bus.rw_wb] <= wdata;
      wcount_q <= wcount_d;
    end
  end

  always_comb begin
    bus.qa_id = regs_q[bus.ra_id];
    if (bus.ra_id == 5'd0)
      bus.qa_id = 32'd0;
    else if (commit && (bus.rw_wb == bus.ra_id))
      bus.qa_id = wdata;
  end

  always_comb begin
    bus.qb_id = regs_q[bus.rb_id];
    if (bus.rb_id == 5'd0)
      bus.qb_id = 32'd0;
    else if (commit && (bus.rw_wb == bus.rb_id))
      bus.qb_id = wdata;
  end

  assign bus.dbg_data = (bus.dbg_addr == 5'd0) ? 32'd0 : regs_q[bus.dbg_addr];
  assign bus.wdata_wb = wdata;
  assign bus.wcount   = wcount_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: inputs change 1ns after a rising edge,
// outputs are checked a few ns later, well before the next edge.
module tb_wb_regfile;
  logic clock;
  logic reset;
  int   checks;
  int   failures;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.ans_wb      = 32'd0;
    bus.mo_wb       = 32'd0;
    bus.rw_wb       = 5'd0;
    bus.wreg_wb     = 1'b0;
    bus.rmem_wb     = 1'b0;
    bus.ra_id       = 5'd0;
    bus.rb_id       = 5'd0;
    bus.dbg_addr    = 5'd0;
    bus.wc_load     = 1'b0;
    bus.wc_load_val = 32'd0;
    edge_step();
    edge_step();
    reset = 1'b0;

    // Clean state after reset
    for (int a = 0; a < 32; a++) begin
      bus.dbg_addr = 5'(a);
      #1;
      check($sformatf("reset_dbg[%0d]", a), bus.dbg_data, 32'd0);
    end
    check("reset_wcount", bus.wcount, 32'd0);

    // ALU writeback to r5 with port A bypass
    bus.wreg_wb = 1'b1; bus.rmem_wb = 1'b0; bus.rw_wb = 5'd5;
    bus.ans_wb = 32'h1234_5678; bus.ra_id = 5'd5; bus.dbg_addr = 5'd5;
    #2;
    check("r5_bypass_qa", bus.qa_id, 32'h1234_5678);
    check("r5_wdata", bus.wdata_wb, 32'h1234_5678);
    check("r5_dbg_pre", bus.dbg_data, 32'd0);
    edge_step();
    bus.wreg_wb = 1'b0;
    #2;
    check("r5_dbg_post", bus.dbg_data, 32'h1234_5678);
    check("r5_qa_stored", bus.qa_id, 32'h1234_5678);
    check("r5_wcount", bus.wcount, 32'd1);

    // Write to r0 is discarded
    bus.wreg_wb = 1'b1; bus.rmem_wb = 1'b1; bus.rw_wb = 5'd0;
    bus.mo_wb = 32'hDEAD_BEEF; bus.ra_id = 5'd0; bus.rb_id = 5'd0; bus.dbg_addr = 5'd0;
    #2;
    check("r0_qa", bus.qa_id, 32'd0);
    check("r0_qb", bus.qb_id, 32'd0);
    check("r0_wdata", bus.wdata_wb, 32'hDEAD_BEEF);
    edge_step();
    bus.wreg_wb = 1'b0;
    #2;
    check("r0_dbg", bus.dbg_data, 32'd0);
    check("r0_wcount", bus.wcount, 32'd1);

    // r7 overwritten by memory data, both ports bypassed
    bus.wreg_wb = 1'b1; bus.rmem_wb = 1'b0; bus.rw_wb = 5'd7; bus.ans_wb = 32'hA5A5_A5A5;
    edge_step();
    bus.rmem_wb = 1'b1; bus.mo_wb = 32'h0000_FFFF;
    bus.ra_id = 5'd7; bus.rb_id = 5'd7; bus.dbg_addr = 5'd7;
    #2;
    check("r7_bypass_qa", bus.qa_id, 32'h0000_FFFF);
    check("r7_bypass_qb", bus.qb_id, 32'h0000_FFFF);
    check("r7_dbg_pre", bus.dbg_data, 32'hA5A5_A5A5);
    edge_step();
    bus.wreg_wb = 1'b0; bus.ra_id = 5'd5;
    #2;
    check("r7_dbg_post", bus.dbg_data, 32'h0000_FFFF);
    check("r7_qb_stored", bus.qb_id, 32'h0000_FFFF);
    check("r5_qa_unchanged", bus.qa_id, 32'h1234_5678);
    check("r7_wcount", bus.wcount, 32'd3);

    // No commit with wreg low, even with rmem undriven; no bypass either
    bus.rmem_wb = 1'bx; bus.rw_wb = 5'd9; bus.ans_wb = 32'h5555_0000;
    bus.ra_id = 5'd9; bus.dbg_addr = 5'd9;
    #2;
    check("nowr_qa", bus.qa_id, 32'd0);
    edge_step();
    #2;
    check("nowr_dbg", bus.dbg_data, 32'd0);
    check("nowr_wcount", bus.wcount, 32'd3);

    // Held inputs commit on every edge
    bus.wreg_wb = 1'b1; bus.rmem_wb = 1'b0; bus.rw_wb = 5'd10;
    bus.ans_wb = 32'h0000_0011; bus.dbg_addr = 5'd10;
    edge_step();
    edge_step();
    bus.ans_wb = 32'h0000_0022;
    edge_step();
    bus.wreg_wb = 1'b0;
    #2;
    check("b2b_dbg", bus.dbg_data, 32'h0000_0022);
    check("b2b_wcount", bus.wcount, 32'd6);

    // Counter wraps through the top
    bus.wc_load = 1'b1; bus.wc_load_val = 32'hFFFF_FFFE;
    edge_step();
    bus.wc_load = 1'b0;
    #2;
    check("wrap_load", bus.wcount, 32'hFFFF_FFFE);
    bus.wreg_wb = 1'b1; bus.rw_wb = 5'd11; bus.ans_wb = 32'h0000_0001;
    edge_step();
    #2;
    check("wrap_max", bus.wcount, 32'hFFFF_FFFF);
    edge_step();
    bus.wreg_wb = 1'b0;
    #2;
    check("wrap_zero", bus.wcount, 32'd0);

    // Async reset mid-cycle clears state; held write during reset is dropped
    bus.wreg_wb = 1'b1; bus.rw_wb = 5'd3; bus.ans_wb = 32'h0000_0001; bus.dbg_addr = 5'd3;
    edge_step();
    bus.wreg_wb = 1'b0;
    #2;
    check("r3_dbg_set", bus.dbg_data, 32'h0000_0001);
    check("r3_wcount", bus.wcount, 32'd1);
    reset = 1'b1;
    #1;
    check("arst_r3", bus.dbg_data, 32'd0);
    check("arst_wcount", bus.wcount, 32'd0);
    bus.dbg_addr = 5'd10;
    #1;
    check("arst_r10", bus.dbg_data, 32'd0);
    bus.dbg_addr = 5'd3; bus.wreg_wb = 1'b1; bus.ans_wb = 32'h0000_0005;
    edge_step();
    check("rst_drop_r3", bus.dbg_data, 32'd0);
    check("rst_drop_wcount", bus.wcount, 32'd0);
    reset = 1'b0;
    edge_step();
    bus.wreg_wb = 1'b0;
    #2;
    check("post_rst_r3", bus.dbg_data, 32'h0000_0005);
    check("post_rst_wcount", bus.wcount, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
